// File: rtl/module_name_fold.sv
// Folds a 32-bit word into a registered 16-bit result.
// Mode 0 gives the ones'-complement sum of the halves; mode 1 gives their XOR.
module module_name_fold #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [IN_W-1:0]  input_example_1_i,
  input  logic             input_example_2_i,
  output logic [OUT_W-1:0] output_example_o
);

  logic [OUT_W-1:0] hi;
  logic [OUT_W-1:0] lo;
  logic [OUT_W:0]   sum;
  logic [OUT_W-1:0] res_d;
  logic [OUT_W-1:0] res_q;

  always_comb begin
    hi    = input_example_1_i[IN_W-1:OUT_W];
    lo    = input_example_1_i[OUT_W-1:0];
    sum   = {1'b0, hi} + {1'b0, lo};
    res_d = '0;
    unique case (input_example_2_i)
      1'b0: begin
        // One end-around carry suffices: hi+lo <= 2^17-2.
        res_d = sum[OUT_W-1:0]
              + {{(OUT_W-1){1'b0}}, sum[OUT_W]};
      end
      1'b1: res_d = hi ^ lo;
      default: res_d = 'x;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) res_q <= '0;
    else         res_q <= res_d;
  end

  assign output_example_o = res_q;

endmodule

// File: tb/tb_module_name_fold.sv
// Scoreboard bench for module_name_fold: stimulus pushes expected
// folds, a monitor pops and compares one cycle later.
module tb_module_name_fold;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] din = '0;
  logic        mode = 1'b0;
  logic [15:0] dout;

  int checks = 0;
  int passes = 0;
  bit active = 1'b0;
  logic [15:0] q[$];

  module_name_fold #(.IN_W(32), .OUT_W(16)) dut (
    .clk_i             (clk),
    .rstn_i            (rstn),
    .input_example_1_i (din),
    .input_example_2_i (mode),
    .output_example_o  (dout)
  );

  always #5 clk = ~clk;

  // Ones'-complement sum is addition modulo 2^16-1, with a nonzero
  // sum that is a multiple of 0xFFFF shown as 0xFFFF (negative zero).
  function automatic logic [15:0] ref_fold(logic [31:0] w, logic m);
    int unsigned t;
    if (m) return w[31:16] ^ w[15:0];
    t = int'(w[31:16]) + int'(w[15:0]);
    if (t == 0) return 16'h0000;
    t = t % 65535;
    if (t == 0) return 16'hFFFF;
    return t[15:0];
  endfunction

  task automatic check(string name, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic drive(logic [31:0] w, logic m);
    din  = w;
    mode = m;
    if (rstn) q.push_back(ref_fold(w, m));
  endtask

  // Monitor: compares after every rising edge.
  always @(posedge clk) begin
    #1;
    if (!rstn) begin
      check("reset_hold", dout, 16'h0000);
    end else if (active) begin
      if (q.size() == 0) check("underflow", dout, 16'hxxxx);
      else check("stream", dout, q.pop_front());
    end
  end

  logic [31:0] dir_w[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'h0006_9F95, 32'h0006_9F95,
                            32'h8000_8000, 32'h0000_0000};
  logic        dir_m[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [15:0] dir_e[6] = '{16'hFFFF, 16'h0000, 16'h9F9B,
                            16'h9F93, 16'h0001, 16'h0000};

  initial begin
    din  = 32'hDEAD_BEEF;
    mode = 1'b1;
    #2;
    check("reset_async", dout, 16'h0000);
    repeat (2) @(posedge clk);

    // Spec-listed vectors against hard constants.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rstn = 1'b1;
      din  = dir_w[i];
      mode = dir_m[i];
      @(posedge clk);
      #1;
      check("directed", dout, dir_e[i]);
      check("model", ref_fold(dir_w[i], dir_m[i]), dir_e[i]);
    end

    active = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      drive($urandom, 1'($urandom_range(0, 1)));
      if (n == 5000) begin
        // Mid-stream reset between edges, then release before the next edge.
        @(posedge clk);
        #2;
        din  = 32'h1234_8765;
        mode = 1'b0;
        rstn = 1'b0;
        #1;
        check("reset_mid", dout, 16'h0000);
        q.delete();
        #1;
        rstn = 1'b1;
        q.push_back(ref_fold(din, mode));
        @(posedge clk);
        #2;
      end
    end

    @(posedge clk);
    #2;
    active = 1'b0;
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL drain: got %0d left expected 0", q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule
